// File: rtl/alu_exec_if.sv
// Request/response bundle between register-read and the ALU execute unit.
// Both sides use valid/ready handshakes; see alu_exec_unit for the transfer rule.
interface alu_exec_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       alu_op;
    logic [5:0]       func;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic [2:0]       op_code;
    logic             illegal;

    modport master (
        output in_valid, alu_op, func, a, b, out_ready,
        input  in_ready, out_valid, result, zero, op_code, illegal
    );

    modport slave (
        input  in_valid, alu_op, func, a, b, out_ready,
        output in_ready, out_valid, result, zero, op_code, illegal
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Sequential ALU execute stage: decodes ALUop/func, runs single-cycle ops directly
// and MUL through an iterative shift-add loop, with registered results.
module alu_exec_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_exec_if.slave  bus,
    output logic [1:0] fsm_state
);

    // Handshake: a request transfers on a rising edge where in_valid && in_ready,
    // a result transfers on a rising edge where out_valid && out_ready. in_ready is
    // high only in IDLE and out_valid only in DONE, so at most one op is in flight.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_NOP = 3'b111;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_next;

    logic [2:0]       dec_op;
    logic             dec_illegal;
    logic [WIDTH-1:0] alu_res;
    logic             accept;
    logic             is_mul;

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [CNT_W-1:0] cnt;
    logic             last_step;

    assign fsm_state = state;
    assign accept    = bus.in_valid && (state == S_IDLE);
    assign is_mul    = (dec_op == OP_MUL);
    assign acc_next  = mplier[0] ? (acc + mcand) : acc;
    assign last_step = (cnt == LAST_STEP);

    // Decoder: R-type selects by func, everything else by ALUop alone.
    always_comb begin
        dec_op      = OP_NOP;
        dec_illegal = 1'b0;
        if (bus.alu_op == 3'b111) begin
            case (bus.func)
                6'b100000: dec_op = OP_ADD;
                6'b100010: dec_op = OP_SUB;
                6'b100100: dec_op = OP_AND;
                6'b100101: dec_op = OP_OR;
                6'b101010: dec_op = OP_SLT;
                6'b000000: dec_op = OP_NOP;
                6'b011000: dec_op = OP_MUL;
                default:   dec_illegal = 1'b1;
            endcase
        end else begin
            case (bus.alu_op)
                3'b101:  dec_op = OP_ADD;
                3'b100:  dec_op = OP_SLT;
                3'b011:  dec_op = OP_AND;
                3'b010:  dec_op = OP_OR;
                3'b001:  dec_op = OP_ADD;
                3'b000:  dec_op = OP_SUB;
                default: dec_illegal = 1'b1;
            endcase
        end
    end

    always_comb begin
        alu_res = '0;
        case (dec_op)
            OP_ADD:  alu_res = bus.a + bus.b;
            OP_SUB:  alu_res = bus.a - bus.b;
            OP_AND:  alu_res = bus.a & bus.b;
            OP_OR:   alu_res = bus.a | bus.b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = is_mul ? S_MUL : S_DONE;
                end
            end
            S_MUL: begin
                if (last_step) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == S_IDLE);
        bus.out_valid = (state == S_DONE);
    end

    // The final multiply step writes the result directly so the result is visible
    // WIDTH+1 cycles after accept; outputs are untouched while MUL iterates.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.result  <= '0;
            bus.zero    <= 1'b0;
            bus.op_code <= OP_NOP;
            bus.illegal <= 1'b0;
            mcand       <= '0;
            mplier      <= '0;
            acc         <= '0;
            cnt         <= '0;
        end else if (accept && !is_mul) begin
            bus.result  <= alu_res;
            bus.zero    <= (alu_res == '0);
            bus.op_code <= dec_op;
            bus.illegal <= dec_illegal;
        end else if (accept) begin
            mcand  <= bus.a;
            mplier <= bus.b;
            acc    <= '0;
            cnt    <= '0;
        end else if (state == S_MUL) begin
            mcand  <= {mcand[WIDTH-2:0], 1'b0};
            mplier <= {1'b0, mplier[WIDTH-1:1]};
            acc    <= acc_next;
            cnt    <= cnt + CNT_W'(1);
            if (last_step) begin
                bus.result  <= acc_next;
                bus.zero    <= (acc_next == '0);
                bus.op_code <= OP_MUL;
                bus.illegal <= 1'b0;
            end
        end
    end

endmodule
